axis_sink_fifo: RTL and testbench

//   AXI4-Stream slave that consumes the 32-bit stream from the xlnxstream master stage.

---
 rtl/axis_sink_fifo_if.sv | 46 ++++
 rtl/axis_sink_fifo.sv | 141 ++++++++++++++
 tb/tb_axis_sink_fifo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_sink_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_sink_fifo_if
// Description : Bundles the AXI4-Stream slave handshake, the FIFO pop port and
//               the status outputs of axis_sink_fifo. The master modport is
//               the stream source / consumer side; the slave modport is the
//               FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_sink_fifo_if #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    // AXI4-Stream beat channel
    logic                 S_AXIS_TVALID;
    logic                 S_AXIS_TREADY;
    logic [31:0]          S_AXIS_TDATA;
    logic [3:0]           S_AXIS_TSTRB;
    logic                 S_AXIS_TLAST;

    // Show-ahead pop port
    logic                 RD_EN;
    logic                 RD_VALID;
    logic [31:0]          RD_DATA;
    logic                 RD_LAST;

    // Status
    logic [c_LVL_W-1:0]   FIFO_LEVEL;
    logic [CNT_WIDTH-1:0] PKT_COUNT;
    logic                 PROTO_ERR;

    modport master (
        output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, RD_EN,
        input  S_AXIS_TREADY, RD_VALID, RD_DATA, RD_LAST,
               FIFO_LEVEL, PKT_COUNT, PROTO_ERR
    );

    modport slave (
        input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, RD_EN,
        output S_AXIS_TREADY, RD_VALID, RD_DATA, RD_LAST,
               FIFO_LEVEL, PKT_COUNT, PROTO_ERR
    );
endinterface
`default_nettype wire

// File: rtl/axis_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_sink_fifo
// Description : AXI4-Stream slave that buffers accepted 32-bit beats (with
//               strobe-masked bytes zeroed) in a show-ahead FIFO, exposes the
//               head on a pop port and counts accepted TLAST beats.
//               Define AXIS_PROTOCOL_CHECK_EN to build the sticky handshake
//               checker driving PROTO_ERR; otherwise PROTO_ERR is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_sink_fifo #(
    parameter int DEPTH     = 4,   // power of two, 2..256
    parameter int CNT_WIDTH = 16
) (
    input  wire logic         S_AXIS_ACLK,
    input  wire logic         S_AXIS_ARESET,
    axis_sink_fifo_if.slave   s_axis
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;

    localparam logic [c_PTR_W-1:0]   c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0]   c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0]   c_LVL_FULL = c_LVL_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    // Storage: {tlast, masked data}
    logic [32:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [CNT_WIDTH-1:0] r_pkt_count;

    logic                 w_tready;
    logic                 w_accept;
    logic                 w_rd_valid;
    logic                 w_pop;
    logic [31:0]          w_masked;
    logic [32:0]          w_head;

    // Ready depends only on registered occupancy and reset, never on TVALID.
    assign w_tready   = !S_AXIS_ARESET && (r_level != c_LVL_FULL);
    assign w_accept   = s_axis.S_AXIS_TVALID && w_tready;
    assign w_rd_valid = (r_level != '0);
    assign w_pop      = s_axis.RD_EN && w_rd_valid;

    // Bytes without their strobe are stored as zero.
    for (genvar b = 0; b < 4; b++) begin : g_strb
        assign w_masked[8*b +: 8] = s_axis.S_AXIS_TSTRB[b] ? s_axis.S_AXIS_TDATA[8*b +: 8] : 8'h00;
    end

    // Data array write; TREADY is low in reset so nothing is written then.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {s_axis.S_AXIS_TLAST, w_masked};
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Completed-packet counter, wraps at 2^CNT_WIDTH.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_pkt_count <= '0;
        end else if (w_accept && s_axis.S_AXIS_TLAST) begin
            r_pkt_count <= r_pkt_count + c_CNT_ONE;
        end
    end

    // Head is forced to zero when empty so the uninitialised array never leaks out.
    assign w_head = w_rd_valid ? r_mem[r_rd_ptr] : 33'd0;

    assign s_axis.S_AXIS_TREADY = w_tready;
    assign s_axis.RD_VALID      = w_rd_valid;
    assign s_axis.RD_DATA       = w_head[31:0];
    assign s_axis.RD_LAST       = w_head[32];
    assign s_axis.FIFO_LEVEL    = r_level;
    assign s_axis.PKT_COUNT     = r_pkt_count;

`ifdef AXIS_PROTOCOL_CHECK_EN
    logic        r_prev_stall;
    logic [31:0] r_prev_data;
    logic [3:0]  r_prev_strb;
    logic        r_prev_last;
    logic        r_proto_err;
    logic        w_violation;

    // A stalled beat must be held unchanged with TVALID still asserted.
    always_comb begin
        w_violation = r_prev_stall &&
                      (!s_axis.S_AXIS_TVALID ||
                       (s_axis.S_AXIS_TDATA != r_prev_data) ||
                       (s_axis.S_AXIS_TSTRB != r_prev_strb) ||
                       (s_axis.S_AXIS_TLAST != r_prev_last));
    end

    // Shadow of last cycle's beat plus the sticky error flag.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_prev_stall <= 1'b0;
            r_prev_data  <= '0;
            r_prev_strb  <= '0;
            r_prev_last  <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_prev_stall <= s_axis.S_AXIS_TVALID && !w_tready;
            r_prev_data  <= s_axis.S_AXIS_TDATA;
            r_prev_strb  <= s_axis.S_AXIS_TSTRB;
            r_prev_last  <= s_axis.S_AXIS_TLAST;
            if (w_violation) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign s_axis.PROTO_ERR = r_proto_err;
`else
    assign s_axis.PROTO_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_sink_fifo
// Description : Self-checking bench for axis_sink_fifo (DEPTH=4). A queue
//               model predicts every output each cycle; directed scenarios
//               are followed by constrained-random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_sink_fifo;
    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = 16;
`ifdef AXIS_PROTOCOL_CHECK_EN
    localparam bit c_CHECK_EN = 1'b1;
`else
    localparam bit c_CHECK_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    axis_sink_fifo_if #(.DEPTH(c_DEPTH), .CNT_WIDTH(c_CNT_W)) bus ();

    axis_sink_fifo #(.DEPTH(c_DEPTH), .CNT_WIDTH(c_CNT_W)) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .s_axis        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // Reference model state
    logic [32:0]        q [$];
    logic [c_CNT_W-1:0] exp_pkts;
    bit                 exp_err;
    bit                 prev_stall;
    logic [31:0]        prev_data;
    logic [3:0]         prev_strb;
    logic               prev_last;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        exp_pkts   = '0;
        exp_err    = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        logic [32:0] head;
        head = (q.size() != 0) ? q[0] : 33'd0;
        check({pfx, "_tready"},  bus.S_AXIS_TREADY, !rst && (q.size() != c_DEPTH));
        check({pfx, "_rdvalid"}, bus.RD_VALID, q.size() != 0);
        check({pfx, "_rddata"},  bus.RD_DATA, head[31:0]);
        check({pfx, "_rdlast"},  bus.RD_LAST, head[32]);
        check({pfx, "_level"},   bus.FIFO_LEVEL, q.size());
        check({pfx, "_pkts"},    bus.PKT_COUNT, exp_pkts);
        check({pfx, "_proto"},   bus.PROTO_ERR, exp_err);
    endtask

    // One clock: compare at negedge, advance model at posedge, return 1 after.
    task automatic cycle();
        bit acc;
        bit pop;
        @(negedge clk);
        check_outputs("cyc");
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            acc = bus.S_AXIS_TVALID && (q.size() < c_DEPTH);
            pop = bus.RD_EN && (q.size() > 0);
            if (c_CHECK_EN && prev_stall &&
                (!bus.S_AXIS_TVALID || bus.S_AXIS_TDATA != prev_data ||
                 bus.S_AXIS_TSTRB != prev_strb || bus.S_AXIS_TLAST != prev_last))
                exp_err = 1'b1;
            prev_stall = bus.S_AXIS_TVALID && !(q.size() < c_DEPTH);
            prev_data  = bus.S_AXIS_TDATA;
            prev_strb  = bus.S_AXIS_TSTRB;
            prev_last  = bus.S_AXIS_TLAST;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back({bus.S_AXIS_TLAST, mask(bus.S_AXIS_TDATA, bus.S_AXIS_TSTRB)});
                if (bus.S_AXIS_TLAST) exp_pkts = exp_pkts + 1'b1;
            end
        end
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l);
        bus.S_AXIS_TVALID = v;
        bus.S_AXIS_TDATA  = d;
        bus.S_AXIS_TSTRB  = s;
        bus.S_AXIS_TLAST  = l;
    endtask

    // Asynchronous assertion, held for one edge, released after it.
    task automatic do_reset(input string pfx);
        rst = 1'b1;
        model_clear();
        #1;
        check({pfx, "_rst_level"},   bus.FIFO_LEVEL, 0);
        check({pfx, "_rst_rdvalid"}, bus.RD_VALID, 1'b0);
        check({pfx, "_rst_pkts"},    bus.PKT_COUNT, 0);
        check({pfx, "_rst_tready"},  bus.S_AXIS_TREADY, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        bit will_stall;
        int rd_bias;
        rst = 1'b1;
        model_clear();
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);
        bus.RD_EN = 1'b0;

        // 1. Reset state and release
        #2;
        check("t1_rst_tready",  bus.S_AXIS_TREADY, 1'b0);
        check("t1_rst_rdvalid", bus.RD_VALID, 1'b0);
        check("t1_rst_rddata",  bus.RD_DATA, 32'h0);
        check("t1_rst_level",   bus.FIFO_LEVEL, 0);
        check("t1_rst_pkts",    bus.PKT_COUNT, 0);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("t1_tready_release", bus.S_AXIS_TREADY, 1'b1);

        // 2. Full back-pressure
        for (int i = 1; i <= 4; i++) begin
            set_beat(1'b1, 32'(i), 4'hF, 1'b0);
            cycle();
        end
        check("t2_level_full", bus.FIFO_LEVEL, 4);
        check("t2_tready_full", bus.S_AXIS_TREADY, 1'b0);
        set_beat(1'b1, 32'h5, 4'hF, 1'b0);
        cycle();
        check("t2_level_stalled", bus.FIFO_LEVEL, 4);
        check("t2_head_before_pop", bus.RD_DATA, 32'h1);
        bus.RD_EN = 1'b1;
        cycle();
        bus.RD_EN = 1'b0;
        check("t2_tready_after_pop", bus.S_AXIS_TREADY, 1'b1);
        cycle();
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);
        check("t2_level_refill", bus.FIFO_LEVEL, 4);
        bus.RD_EN = 1'b1;
        repeat (4) cycle();
        bus.RD_EN = 1'b0;
        check("t2_level_drained", bus.FIFO_LEVEL, 0);

        // 3. Packet with strobes
        set_beat(1'b1, 32'h11, 4'hF, 1'b0);          cycle();
        set_beat(1'b1, 32'h22, 4'hF, 1'b0);          cycle();
        set_beat(1'b1, 32'hAABBCCDD, 4'b0011, 1'b1); cycle();
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);
        bus.RD_EN = 1'b1;
        cycle();
        cycle();
        check("t3_strb_data", bus.RD_DATA, 32'h0000CCDD);
        check("t3_strb_last", bus.RD_LAST, 1'b1);
        check("t3_pkts",      bus.PKT_COUNT, 1);
        cycle();
        bus.RD_EN = 1'b0;

        // 4. Concurrent accept and pop at level 2
        set_beat(1'b1, 32'hA0, 4'hF, 1'b0); cycle();
        set_beat(1'b1, 32'hA1, 4'hF, 1'b0); cycle();
        bus.RD_EN = 1'b1;
        for (int i = 2; i < 6; i++) begin
            set_beat(1'b1, 32'hA0 + 32'(i), 4'hF, 1'b0);
            cycle();
            check("t4_level_steady", bus.FIFO_LEVEL, 2);
        end
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);
        repeat (2) cycle();
        bus.RD_EN = 1'b0;
        cycle();

        // 5. Protocol violation while stalled
        for (int i = 1; i <= 4; i++) begin
            set_beat(1'b1, 32'(i), 4'hF, 1'b0);
            cycle();
        end
        set_beat(1'b1, 32'h5, 4'hF, 1'b0); cycle();
        set_beat(1'b1, 32'h6, 4'hF, 1'b0); cycle();
        check("t5_proto_set", bus.PROTO_ERR, c_CHECK_EN);
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);
        bus.RD_EN = 1'b1;
        repeat (3) cycle();
        check("t5_proto_sticky", bus.PROTO_ERR, c_CHECK_EN);
        bus.RD_EN = 1'b0;
        do_reset("t5");
        cycle();

        // 6. Reset mid-packet
        set_beat(1'b1, 32'h31, 4'hF, 1'b0); cycle();
        set_beat(1'b1, 32'h32, 4'hF, 1'b0); cycle();
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);
        do_reset("t6");
        set_beat(1'b1, 32'h77, 4'hF, 1'b1); cycle();
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);  cycle();
        check("t6_pkts_after", bus.PKT_COUNT, 1);
        check("t6_head_after", bus.RD_DATA, 32'h77);

        // Randomised traffic with a mostly compliant master
        do_reset("rnd0");
        will_stall = 1'b0;
        for (int n = 0; n < 900; n++) begin
            rd_bias = (n < 300) ? 25 : ((n < 600) ? 75 : 50);
            if (!will_stall) begin
                set_beat($urandom_range(0, 99) < 70, $urandom, 4'($urandom), $urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 149) == 0) begin
                bus.S_AXIS_TDATA = bus.S_AXIS_TDATA ^ 32'h1;
            end
            bus.RD_EN = $urandom_range(0, 99) < rd_bias;
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd");
                will_stall = 1'b0;
            end else begin
                will_stall = bus.S_AXIS_TVALID && (q.size() == c_DEPTH);
                cycle();
            end
        end
        set_beat(1'b0, 32'h0, 4'hF, 1'b0);
        bus.RD_EN = 1'b1;
        repeat (6) cycle();
        check("end_level_empty", bus.FIFO_LEVEL, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
